mc_arbiter: RTL and testbench

- Shares one motion-compensation engine between two requester streams, luma and chroma.
- Grants the engine for one whole block at a time: ROWS input rows in, ROWS residual rows out.
- Drives the engine's chroma-select input (ccin) and returns residual rows tagged with requester and row index.
- Sits between the luma/chroma row fetchers and the mc engine; the transform stage consumes the residual output.

---
 rtl/mc_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mc_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_arbiter.sv
// mc_arbiter: grants one motion-compensation engine to the luma or chroma
// row stream for a whole block (ROWS rows in, ROWS residual rows out).
//
// Ports
//   clk, reset            clock, async active-low reset
//   luma_*                luma requester: valid/ready + ref/curr rows
//   chroma_*              chroma requester: valid/ready + ref/curr rows
//   mc_src_*              muxed rows to the engine (ref_frame, curr_mb)
//   mc_ccin               1 while a chroma block owns the engine
//   mc_dst_*, mc_residual residual rows coming back from the engine
//   res_*                 residual rows to the transform stage, tagged
//                         with requester (res_is_chroma) and row index
//   blk_done              one-cycle pulse after a block completes
//   protocol_err          sticky: engine produced a residual while idle
module mc_arbiter #(
   parameter int MB_SIZE     = 4,
   parameter int PIXEL_WIDTH = 8,
   parameter int ROWS        = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   // luma requester
   input  logic                          luma_valid,
   output logic                          luma_ready,
   input  logic [PIXEL_WIDTH*MB_SIZE-1:0] luma_ref,
   input  logic [PIXEL_WIDTH*MB_SIZE-1:0] luma_curr,
   // chroma requester
   input  logic                          chroma_valid,
   output logic                          chroma_ready,
   input  logic [PIXEL_WIDTH*MB_SIZE-1:0] chroma_ref,
   input  logic [PIXEL_WIDTH*MB_SIZE-1:0] chroma_curr,
   // engine source side
   output logic                          mc_src_valid,
   input  logic                          mc_src_ready,
   output logic [PIXEL_WIDTH*MB_SIZE-1:0] mc_ref_frame,
   output logic [PIXEL_WIDTH*MB_SIZE-1:0] mc_curr_mb,
   output logic                          mc_ccin,
   // engine destination side
   input  logic                          mc_dst_valid,
   output logic                          mc_dst_ready,
   input  logic [PIXEL_WIDTH*MB_SIZE-1:0] mc_residual,
   // residual output
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic [PIXEL_WIDTH*MB_SIZE-1:0] res_data,
   output logic                          res_is_chroma,
   output logic [$clog2(ROWS)-1:0]       res_row,
   // status
   output logic                          blk_done,
   output logic                          protocol_err
);

   localparam int DW = PIXEL_WIDTH * MB_SIZE;
   localparam int CW = $clog2(ROWS + 1);
   localparam int RW = $clog2(ROWS);

   localparam logic [CW-1:0] ROWS_C = CW'(ROWS);
   localparam logic [CW-1:0] ONE_C  = CW'(1);

   typedef enum logic {
      IDLE,
      BUSY
   } state_e;

   state_e        state_q, state_d;
   logic          grant_chroma_q, grant_chroma_d;
   logic          last_chroma_q, last_chroma_d;
   logic [CW-1:0] in_cnt_q, in_cnt_d;
   logic [CW-1:0] out_cnt_q, out_cnt_d;
   logic          blk_done_q, blk_done_d;
   logic          protocol_err_q, protocol_err_d;

   logic          in_open;
   logic          out_open;
   logic          gnt_valid;
   logic          src_hs;
   logic          res_hs;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         grant_chroma_q <= 1'b0;
         last_chroma_q  <= 1'b1;
         in_cnt_q       <= '0;
         out_cnt_q      <= '0;
         blk_done_q     <= 1'b0;
         protocol_err_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         grant_chroma_q <= grant_chroma_d;
         last_chroma_q  <= last_chroma_d;
         in_cnt_q       <= in_cnt_d;
         out_cnt_q      <= out_cnt_d;
         blk_done_q     <= blk_done_d;
         protocol_err_q <= protocol_err_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      grant_chroma_d = grant_chroma_q;
      last_chroma_d  = last_chroma_q;
      in_cnt_d       = in_cnt_q;
      out_cnt_d      = out_cnt_q;
      blk_done_d     = 1'b0;
      protocol_err_d = protocol_err_q;

      in_open   = 1'b0;
      out_open  = 1'b0;
      gnt_valid = 1'b0;
      src_hs    = 1'b0;
      res_hs    = 1'b0;

      luma_ready    = 1'b0;
      chroma_ready  = 1'b0;
      mc_src_valid  = 1'b0;
      mc_ref_frame  = '0;
      mc_curr_mb    = '0;
      mc_ccin       = 1'b0;
      mc_dst_ready  = 1'b0;
      res_valid     = 1'b0;
      res_data      = '0;
      res_is_chroma = 1'b0;
      res_row       = '0;

      unique case (state_q)
         IDLE: begin
            // An engine residual with no block in flight is a protocol fault.
            if (mc_dst_valid) begin
               protocol_err_d = 1'b1;
            end
            if (luma_valid || chroma_valid) begin
               state_d   = BUSY;
               in_cnt_d  = '0;
               out_cnt_d = '0;
               // On a tie the requester that did not own the last block wins.
               if (luma_valid && chroma_valid) begin
                  grant_chroma_d = ~last_chroma_q;
               end else begin
                  grant_chroma_d = chroma_valid;
               end
            end
         end

         BUSY: begin
            in_open  = (in_cnt_q < ROWS_C);
            out_open = (out_cnt_q < ROWS_C);

            mc_ccin   = grant_chroma_q;
            gnt_valid = grant_chroma_q ? chroma_valid : luma_valid;

            mc_src_valid = gnt_valid && in_open;
            luma_ready   = !grant_chroma_q && mc_src_ready && in_open;
            chroma_ready = grant_chroma_q && mc_src_ready && in_open;
            mc_ref_frame = grant_chroma_q ? chroma_ref : luma_ref;
            mc_curr_mb   = grant_chroma_q ? chroma_curr : luma_curr;

            res_valid     = mc_dst_valid && out_open;
            mc_dst_ready  = res_ready && out_open;
            res_data      = mc_residual;
            res_is_chroma = grant_chroma_q;
            res_row       = out_cnt_q[RW-1:0];

            src_hs = mc_src_valid && mc_src_ready;
            res_hs = res_valid && res_ready;

            if (src_hs) begin
               in_cnt_d = in_cnt_q + ONE_C;
            end
            if (res_hs) begin
               out_cnt_d = out_cnt_q + ONE_C;
            end

            // Release only once every row went in and every residual came out.
            if ((in_cnt_d == ROWS_C) && (out_cnt_d == ROWS_C)) begin
               state_d       = IDLE;
               last_chroma_d = grant_chroma_q;
               blk_done_d    = 1'b1;
               in_cnt_d      = '0;
               out_cnt_d     = '0;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign blk_done     = blk_done_q;
   assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_mc_arbiter.sv
// tb_mc_arbiter: directed scenarios plus a randomized phase for mc_arbiter,
// checked cycle by cycle against a block-level reference model.
module tb_mc_arbiter;

   localparam int DW   = 32;
   localparam int ROWS = 4;

   typedef struct packed {
      logic [DW-1:0] r;
      logic [DW-1:0] c;
   } row_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          luma_valid, luma_ready;
   logic [DW-1:0] luma_ref, luma_curr;
   logic          chroma_valid, chroma_ready;
   logic [DW-1:0] chroma_ref, chroma_curr;
   logic          mc_src_valid, mc_src_ready;
   logic [DW-1:0] mc_ref_frame, mc_curr_mb;
   logic          mc_ccin;
   logic          mc_dst_valid, mc_dst_ready;
   logic [DW-1:0] mc_residual;
   logic          res_valid, res_ready;
   logic [DW-1:0] res_data;
   logic          res_is_chroma;
   logic [1:0]    res_row;
   logic          blk_done, protocol_err;

   always #5 clk = ~clk;

   mc_arbiter #(.MB_SIZE(4), .PIXEL_WIDTH(8), .ROWS(ROWS)) dut (
      .clk(clk), .reset(reset),
      .luma_valid(luma_valid), .luma_ready(luma_ready),
      .luma_ref(luma_ref), .luma_curr(luma_curr),
      .chroma_valid(chroma_valid), .chroma_ready(chroma_ready),
      .chroma_ref(chroma_ref), .chroma_curr(chroma_curr),
      .mc_src_valid(mc_src_valid), .mc_src_ready(mc_src_ready),
      .mc_ref_frame(mc_ref_frame), .mc_curr_mb(mc_curr_mb),
      .mc_ccin(mc_ccin),
      .mc_dst_valid(mc_dst_valid), .mc_dst_ready(mc_dst_ready),
      .mc_residual(mc_residual),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_is_chroma(res_is_chroma),
      .res_row(res_row),
      .blk_done(blk_done), .protocol_err(protocol_err)
   );

   int tests = 0;
   int fails = 0;

   // environment: requester row queues and an engine pipeline
   row_t          lq[$];
   row_t          cq[$];
   logic [DW-1:0] eq[$];
   int l_pct = 100, c_pct = 100, src_pct = 100, dst_pct = 100, res_pct = 100;
   int res_hold = 0, l_gap = 0;
   bit res_hold_arm = 0, l_gap_arm = 0, pulse_dst = 0;

   // reference model, block-level view
   bit            m_busy = 0, m_own = 0, m_last = 1, m_perr = 0, m_done = 0;
   bit            m_first = 0;
   int            m_sent = 0, m_recv = 0;
   logic [DW-1:0] m_blk[$];
   logic          obs_cc[$];

   function automatic logic [DW-1:0] resid(row_t x);
      logic [DW-1:0] d;
      for (int i = 0; i < 4; i++) d[8*i +: 8] = x.r[8*i +: 8] - x.c[8*i +: 8];
      return d;
   endfunction

   task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_rows(bit chroma, int nblk, bit ramp);
      row_t x;
      for (int b = 0; b < nblk; b++) begin
         for (int i = 0; i < ROWS; i++) begin
            x.r = ramp ? 32'h01020304 + 32'h04040404 * i : $urandom;
            x.c = $urandom;
            if (chroma) cq.push_back(x);
            else lq.push_back(x);
         end
      end
   endtask

   task automatic cycle();
      logic el, ec, ed;
      logic e_lr, e_cr, e_sv, e_cc, e_dr, e_rv, in_open, out_open;
      logic [127:0] exp_src;
      row_t cur;
      @(negedge clk);
      el = lq.size() > 0 && l_gap == 0 && $urandom_range(99) < l_pct;
      ec = cq.size() > 0 && $urandom_range(99) < c_pct;
      ed = pulse_dst || (eq.size() > 0 && $urandom_range(99) < dst_pct);
      luma_valid   = el;
      luma_ref     = lq.size() > 0 ? lq[0].r : $urandom;
      luma_curr    = lq.size() > 0 ? lq[0].c : $urandom;
      chroma_valid = ec;
      chroma_ref   = cq.size() > 0 ? cq[0].r : $urandom;
      chroma_curr  = cq.size() > 0 ? cq[0].c : $urandom;
      mc_src_ready = $urandom_range(99) < src_pct;
      mc_dst_valid = ed;
      mc_residual  = eq.size() > 0 ? eq[0] : $urandom;
      res_ready    = res_hold > 0 ? 1'b0 : ($urandom_range(99) < res_pct);
      #1;
      in_open  = m_busy && m_sent < ROWS;
      out_open = m_busy && m_recv < ROWS;
      e_lr = in_open && !m_own && mc_src_ready;
      e_cr = in_open && m_own && mc_src_ready;
      e_sv = in_open && (m_own ? ec : el);
      e_cc = m_busy && m_own;
      e_dr = out_open && res_ready;
      e_rv = out_open && ed;
      chk("ctl", 128'({luma_ready, chroma_ready, mc_src_valid, mc_ccin,
                       mc_dst_ready, res_valid, blk_done, protocol_err}),
                 128'({e_lr, e_cr, e_sv, e_cc, e_dr, e_rv, m_done, m_perr}));
      exp_src = !m_busy ? '0 : m_own ? 128'({chroma_ref, chroma_curr})
                                      : 128'({luma_ref, luma_curr});
      chk("src", 128'({mc_ref_frame, mc_curr_mb}), exp_src);
      if (e_rv && m_recv < m_blk.size())
         chk("res", 128'({res_data, res_row, res_is_chroma}),
                    128'({m_blk[m_recv], 2'(m_recv), m_own}));
      if (m_first) begin
         obs_cc.push_back(mc_ccin);
         m_first = 0;
      end
      // advance environment and model with the expected handshakes
      if (ed && e_dr) void'(eq.pop_front());
      if (e_sv && mc_src_ready) begin
         cur = m_own ? cq.pop_front() : lq.pop_front();
         eq.push_back(resid(cur));
         m_blk.push_back(resid(cur));
         m_sent++;
      end
      if (e_rv && res_ready) m_recv++;
      if (res_hold > 0) res_hold--;
      if (l_gap > 0) l_gap--;
      m_done = 0;
      if (!m_busy) begin
         if (ed) m_perr = 1;
         if (el || ec) begin
            m_busy  = 1;
            m_own   = (el && ec) ? !m_last : ec;
            m_sent  = 0;
            m_recv  = 0;
            m_first = 1;
            m_blk.delete();
         end
      end else if (m_sent == ROWS && m_recv == ROWS) begin
         m_busy = 0;
         m_last = m_own;
         m_done = 1;
      end
      if (res_hold_arm && m_busy && m_own && m_recv == 2) begin
         res_hold = 3;
         res_hold_arm = 0;
      end
      if (l_gap_arm && m_busy && !m_own && m_sent == 2) begin
         l_gap = 5;
         l_gap_arm = 0;
      end
   endtask

   task automatic drain(string tag, int maxc);
      int n = 0;
      while ((lq.size() > 0 || cq.size() > 0 || eq.size() > 0 ||
              m_busy || m_done) && n < maxc) begin
         cycle();
         n++;
      end
      tests++;
      assert (n < maxc) else begin
         fails++;
         $error("FAIL %s_timeout observed=%0d cycles limit=%0d", tag, n, maxc);
      end
   endtask

   task automatic chk_all_zero(string tag);
      chk({tag, "_ctl"}, 128'({luma_ready, chroma_ready, mc_src_valid, mc_ccin,
                               mc_dst_ready, res_valid, blk_done, protocol_err}),
          '0);
      chk({tag, "_src"}, 128'({mc_ref_frame, mc_curr_mb}), '0);
      chk({tag, "_res"}, 128'({res_data, res_row, res_is_chroma}), '0);
   endtask

   initial begin
      int n;
      reset = 1'b0;
      luma_valid = 0; luma_ref = '0; luma_curr = '0;
      chroma_valid = 0; chroma_ref = '0; chroma_curr = '0;
      mc_src_ready = 0; mc_dst_valid = 0; mc_residual = '0; res_ready = 0;
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // both requesters from reset: luma, chroma, luma, chroma
      push_rows(0, 2, 0);
      push_rows(1, 2, 0);
      obs_cc.delete();
      drain("rr", 200);
      chk("rr_blocks", 128'(obs_cc.size()), 128'(4));
      for (int i = 0; i < obs_cc.size() && i < 4; i++)
         chk("rr_order", 128'(obs_cc[i]), 128'(i % 2));

      // luma only, ramp reference rows
      push_rows(0, 1, 1);
      obs_cc.delete();
      drain("luma", 100);
      chk("luma_ccin", 128'(obs_cc.size() > 0 ? obs_cc[0] : 1'bx), 128'(0));

      // chroma, downstream stalls three cycles at row 2
      push_rows(1, 1, 0);
      res_hold_arm = 1;
      drain("stall", 100);

      // luma drops valid after row 1 while chroma keeps asking
      push_rows(0, 1, 0);
      cycle();
      push_rows(1, 1, 0);
      l_gap_arm = 1;
      obs_cc.delete();
      drain("gap", 200);
      chk("gap_blocks", 128'(obs_cc.size()), 128'(2));
      if (obs_cc.size() == 2)
         chk("gap_order", 128'({obs_cc[0], obs_cc[1]}), 128'(2'b01));

      // engine residual while idle
      pulse_dst = 1;
      cycle();
      pulse_dst = 0;
      cycle();
      cycle();
      chk("perr_sticky", 128'(protocol_err), 128'(1));

      // reset in the middle of a block
      push_rows(0, 1, 0);
      push_rows(1, 1, 0);
      n = 0;
      while (!(m_busy && m_sent == 2) && n < 50) begin
         cycle();
         n++;
      end
      chk("mid_reach", 128'(n < 50), 128'(1));
      @(negedge clk);
      reset = 1'b0;
      luma_valid = 0; chroma_valid = 0; mc_dst_valid = 0;
      #1;
      chk_all_zero("midreset");
      m_busy = 0; m_last = 1; m_perr = 0; m_done = 0; m_first = 0;
      m_sent = 0; m_recv = 0;
      m_blk.delete(); lq.delete(); cq.delete(); eq.delete();
      res_hold = 0; l_gap = 0; res_hold_arm = 0; l_gap_arm = 0;
      @(negedge clk);
      reset = 1'b1;
      push_rows(0, 1, 0);
      push_rows(1, 1, 0);
      obs_cc.delete();
      drain("post_reset", 200);
      chk("post_reset_first", 128'(obs_cc.size() > 0 ? obs_cc[0] : 1'bx),
          128'(0));

      // randomized traffic
      l_pct = 70; c_pct = 70; src_pct = 70; dst_pct = 60; res_pct = 70;
      for (int k = 0; k < 12; k++) push_rows($urandom_range(1), 1, 0);
      drain("random", 4000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
